des_round_sequencer: RTL and testbench

Iterative DES controller that runs one shared single-round datapath 16 times to encrypt or decrypt one 64-bit block. It applies IP on load and FP on completion, and holds the L/R state register. It generates the 16 subkeys on the fly from a 64-bit key using PC-1, per-round rotation and PC-2. It sits between a valid/ready block source and sink, and drives the combinational round datapath (expansion, S-boxes, P, swap) through the `rnd_*` ports.

---
 rtl/des_round_sequencer_if.sv | 37 +++
 rtl/des_round_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_des_round_sequencer.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/des_round_sequencer_if.sv
// Purpose: handshake and round-datapath bundle for des_round_sequencer.
//   All 64-bit words use FIPS 46-3 bit order: index 1 is the MSB.
// Signals:
//   in_valid/in_ready      block source handshake
//   in_data, in_key        plaintext/ciphertext and key (parity bits ignored)
//   in_decrypt             mode, sampled on accept
//   rnd_in, rnd_key        state and subkey driven to the round datapath
//   rnd_out                round datapath result {R, L ^ f(R, K)}
//   out_valid/out_ready    result sink handshake
//   out_data               final FP-permuted result
//   busy, round_idx        status
// Modports: slave = sequencer side, master = source/sink/datapath side.
interface des_round_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:64] in_data;
    logic [1:64] in_key;
    logic        in_decrypt;
    logic [1:64] rnd_in;
    logic [1:48] rnd_key;
    logic [1:64] rnd_out;
    logic        out_valid;
    logic        out_ready;
    logic [1:64] out_data;
    logic        busy;
    logic [4:0]  round_idx;

    modport slave (
        input  in_valid, in_data, in_key, in_decrypt, rnd_out, out_ready,
        output in_ready, rnd_in, rnd_key, out_valid, out_data, busy, round_idx
    );

    modport master (
        output in_valid, in_data, in_key, in_decrypt, rnd_out, out_ready,
        input  in_ready, rnd_in, rnd_key, out_valid, out_data, busy, round_idx
    );
endinterface

// File: rtl/des_round_sequencer.sv
// Purpose: iterative DES controller. Runs an external single-round datapath
//   16 times per block, applies IP on load and FP on the result, and derives
//   the subkeys on the fly (PC-1, per-round rotation of C/D, PC-2).
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      des_round_sequencer_if.slave (source, sink and round datapath)
// Configuration:
//   DES_DECRYPT_EN  when defined, in_decrypt selects decryption (subkeys are
//                   walked backwards with right rotations). When undefined
//                   the decrypt logic is absent and every block encrypts.
// Timing: accept at edge t0, rounds at t1..t16, out_valid from t16 until the
//   output handshake; a new block may be accepted on that same edge.
module des_round_sequencer (
    input  logic                  clk,
    input  logic                  rst_n,
    des_round_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // FIPS 46-3 tables; entry n gives the source bit for output bit n+1.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [1:64] ip_perm(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 1; i <= 64; i++) y[i] = x[IP_T[i-1]];
        return y;
    endfunction

    function automatic logic [1:64] fp_perm(input logic [1:64] x);
        logic [1:64] y;
        for (int i = 1; i <= 64; i++) y[i] = x[FP_T[i-1]];
        return y;
    endfunction

    function automatic logic [1:56] pc1_perm(input logic [1:64] k);
        logic [1:56] y;
        for (int i = 1; i <= 56; i++) y[i] = k[PC1_T[i-1]];
        return y;
    endfunction

    function automatic logic [1:48] pc2_perm(input logic [1:56] v);
        logic [1:48] y;
        for (int i = 1; i <= 48; i++) y[i] = v[PC2_T[i-1]];
        return y;
    endfunction

    // Shift schedule: rounds 1, 2, 9 and 16 rotate by one, all others by two.
    function automatic logic double_shift(input logic [4:0] r);
        return !(r == 5'd1 || r == 5'd2 || r == 5'd9 || r == 5'd16);
    endfunction

    // C and D are rotated independently; index 1 is the MSB, so "left"
    // moves bits toward index 1.
    function automatic logic [1:56] rotl(input logic [1:56] v, input logic two);
        logic [1:28] c;
        logic [1:28] d;
        c = v[1:28];
        d = v[29:56];
        if (two) return {c[3:28], c[1:2], d[3:28], d[1:2]};
        return {c[2:28], c[1], d[2:28], d[1]};
    endfunction

`ifdef DES_DECRYPT_EN
    function automatic logic [1:56] rotr(input logic [1:56] v, input logic two);
        logic [1:28] c;
        logic [1:28] d;
        c = v[1:28];
        d = v[29:56];
        if (two) return {c[27:28], c[1:26], d[27:28], d[1:26]};
        return {c[28], c[1:27], d[28], d[1:27]};
    endfunction
`endif

    state_t      state;
    logic [1:64] lr;
    logic [1:56] cd;
    logic [4:0]  cnt;
    logic        out_valid_q;
    logic        busy_q;

    logic        accept;
    logic [1:56] load_cd;
    logic [1:56] round_cd;

    assign bus.in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef DES_DECRYPT_EN
    // Latched mode; only meaningful while a block is in flight.
    logic dec;

    // Decrypt starts from C0D0 (== C16D16) so K16 is presented first;
    // encrypt pre-rotates once so K1 is presented in the first round.
    always_comb begin
        load_cd = bus.in_decrypt ? pc1_perm(bus.in_key)
                                 : rotl(pc1_perm(bus.in_key), 1'b0);
    end

    always_comb begin
        // NOTE: defaulting every always_comb output first keeps the block
        // free of inferred latches on paths that skip an assignment.
        round_cd = cd;
        if (cnt != 5'd16) begin
            round_cd = dec ? rotr(cd, double_shift(5'd17 - cnt))
                           : rotl(cd, double_shift(cnt + 5'd1));
        end
    end
`else
    // Encrypt-only build: the mode input has no effect.
    logic unused_decrypt;
    assign unused_decrypt = bus.in_decrypt;

    always_comb begin
        load_cd = rotl(pc1_perm(bus.in_key), 1'b0);
    end

    always_comb begin
        // NOTE: defaulting every always_comb output first keeps the block
        // free of inferred latches on paths that skip an assignment.
        round_cd = cd;
        if (cnt != 5'd16) round_cd = rotl(cd, double_shift(cnt + 5'd1));
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order. All state,
    // including the wide lr/cd words, is reset so outputs are defined (zero)
    // while rst_n is low and an in-flight block is discarded immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lr          <= '0;
            cd          <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef DES_DECRYPT_EN
            dec         <= 1'b0;
`endif
        end else if (accept) begin
            // Accept is only possible in IDLE, or in DONE on the output
            // handshake edge, so both paths share this load.
            state       <= ROUND;
            lr          <= ip_perm(bus.in_data);
            cd          <= load_cd;
            cnt         <= 5'd1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
`ifdef DES_DECRYPT_EN
            dec         <= bus.in_decrypt;
`endif
        end else begin
            case (state)
                ROUND: begin
                    lr  <= bus.rnd_out;
                    cd  <= round_cd;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd16) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                IDLE: ;
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rnd_in    = lr;
    assign bus.rnd_key   = pc2_perm(cd);
    // The last round leaves {L16,R16}; the output undoes that final swap.
    assign bus.out_data  = fp_perm({lr[33:64], lr[1:32]});
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.round_idx = (state == ROUND) ? cnt : 5'd0;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Purpose: self-checking bench for des_round_sequencer. Provides the
//   combinational DES round datapath (E, S-boxes, P, swap) on rnd_out and
//   checks known-answer vectors, back-to-back throughput, backpressure and
//   mid-block reset. Decrypt expectations follow DES_DECRYPT_EN.
module tb_des_round_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    des_round_sequencer_if bus();

    des_round_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int S_T [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11
    };

    function automatic logic [1:32] f_func(input logic [1:32] r, input logic [1:48] k);
        logic [1:48] x;
        logic [1:32] s;
        logic [1:32] p;
        int row;
        int col;
        int v;
        for (int i = 1; i <= 48; i++) x[i] = r[E_T[i-1]] ^ k[i];
        for (int b = 0; b < 8; b++) begin
            row = {30'd0, x[6*b+1], x[6*b+6]};
            col = {28'd0, x[6*b+2 +: 4]};
            v   = S_T[b*64 + row*16 + col];
            s[4*b+1 +: 4] = v[3:0];
        end
        for (int i = 1; i <= 32; i++) p[i] = s[P_T[i-1]];
        return p;
    endfunction

    // Combinational round datapath: {L,R} -> {R, L ^ f(R,K)}.
    always_comb begin
        bus.rnd_out = {bus.rnd_in[33:64], bus.rnd_in[1:32] ^ f_func(bus.rnd_in[33:64], bus.rnd_key)};
    end

    typedef struct {
        logic [1:64] key;
        logic [1:64] data;
        logic        dec;
        logic [1:64] exp_out;
        logic        chk_k1;
        logic [1:48] exp_k1;
    } vec_t;

    vec_t vecs [3];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a block and return just after its accept edge; inputs are then
    // scrambled so any late use of them corrupts the result.
    task automatic send(input logic [1:64] key, input logic [1:64] data, input logic dec, input string tag);
        int waited;
        waited         = 0;
        bus.in_key     = key;
        bus.in_data    = data;
        bus.in_decrypt = dec;
        bus.in_valid   = 1'b1;
        while (!bus.in_ready && waited < 40) begin
            step();
            waited++;
        end
        check({tag, " in_ready_seen"}, 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid   = 1'b0;
        bus.in_data    = ~data;
        bus.in_key     = ~key;
        bus.in_decrypt = ~dec;
    endtask

    task automatic run_to_done(output int cycles);
        cycles = 0;
        while (!bus.out_valid && cycles < 40) begin
            step();
            cycles++;
        end
    endtask

    int cyc;
    logic ok;
    logic stable;
    logic rdy_low;

    initial begin
        vecs[0] = '{key: 64'h133457799BBCDFF1, data: 64'h0123456789ABCDEF, dec: 1'b0,
                    exp_out: 64'h85E813540F0AB405, chk_k1: 1'b1, exp_k1: 48'h1B02EFFC7072};
        vecs[1] = '{key: 64'h0E329232EA6D0D73, data: 64'h8787878787878787, dec: 1'b0,
                    exp_out: 64'h0000000000000000, chk_k1: 1'b0, exp_k1: 48'h0};
`ifdef DES_DECRYPT_EN
        vecs[2] = '{key: 64'h133457799BBCDFF1, data: 64'h85E813540F0AB405, dec: 1'b1,
                    exp_out: 64'h0123456789ABCDEF, chk_k1: 1'b1, exp_k1: 48'hCB3D8B0E17F5};
`else
        vecs[2] = '{key: 64'h133457799BBCDFF1, data: 64'h0123456789ABCDEF, dec: 1'b1,
                    exp_out: 64'h85E813540F0AB405, chk_k1: 1'b1, exp_k1: 48'h1B02EFFC7072};
`endif

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_key     = '0;
        bus.in_decrypt = 1'b0;
        bus.out_ready  = 1'b1;
        #12;

        // Reset state
        check("rst in_ready",  64'(bus.in_ready),  64'd1);
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst busy",      64'(bus.busy),      64'd0);
        check("rst round_idx", 64'(bus.round_idx), 64'd0);
        check("rst rnd_in",    bus.rnd_in,         64'd0);
        check("rst rnd_key",   64'(bus.rnd_key),   64'd0);
        check("rst out_data",  bus.out_data,       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table-driven known-answer vectors
        for (int i = 0; i < 3; i++) begin
            send(vecs[i].key, vecs[i].data, vecs[i].dec, $sformatf("vec%0d", i));
            check($sformatf("vec%0d round1 idx", i), 64'(bus.round_idx), 64'd1);
            check($sformatf("vec%0d busy", i), 64'(bus.busy), 64'd1);
            if (vecs[i].chk_k1)
                check($sformatf("vec%0d round1 rnd_key", i), 64'(bus.rnd_key), 64'(vecs[i].exp_k1));
            ok = 1'b1;
            for (int k = 1; k <= 15; k++) begin
                step();
                if (bus.round_idx !== 5'(k + 1) || bus.out_valid !== 1'b0) ok = 1'b0;
            end
            check($sformatf("vec%0d round_idx sequence", i), 64'(ok), 64'd1);
            step();
            check($sformatf("vec%0d out_valid at t16", i), 64'(bus.out_valid), 64'd1);
            check($sformatf("vec%0d out_data", i), bus.out_data, vecs[i].exp_out);
            check($sformatf("vec%0d round_idx in DONE", i), 64'(bus.round_idx), 64'd0);
            step();
            check($sformatf("vec%0d out_valid after handshake", i), 64'(bus.out_valid), 64'd0);
            check($sformatf("vec%0d busy after handshake", i), 64'(bus.busy), 64'd0);
        end

        // Back-to-back: second accept on the DONE edge, 17-cycle period
        bus.out_ready = 1'b1;
        send(vecs[0].key, vecs[0].data, 1'b0, "b2b first");
        run_to_done(cyc);
        check("b2b first latency", 64'(cyc), 64'd16);
        check("b2b first out_data", bus.out_data, vecs[0].exp_out);
        check("b2b in_ready in DONE", 64'(bus.in_ready), 64'd1);
        send(vecs[1].key, vecs[1].data, 1'b0, "b2b second");
        check("b2b second round_idx", 64'(bus.round_idx), 64'd1);
        check("b2b out_valid dropped", 64'(bus.out_valid), 64'd0);
        run_to_done(cyc);
        check("b2b second latency", 64'(cyc), 64'd16);
        check("b2b second out_data", bus.out_data, vecs[1].exp_out);
        step();

        // Backpressure: DONE held, new offer ignored
        bus.out_ready = 1'b0;
        send(vecs[0].key, vecs[0].data, 1'b0, "bp");
        run_to_done(cyc);
        check("bp latency", 64'(cyc), 64'd16);
        bus.in_valid = 1'b1;
        bus.in_key   = vecs[1].key;
        bus.in_data  = vecs[1].data;
        stable  = 1'b1;
        rdy_low = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.out_data !== vecs[0].exp_out || bus.out_valid !== 1'b1) stable = 1'b0;
            if (bus.in_ready !== 1'b0) rdy_low = 1'b0;
        end
        check("bp out_data stable", 64'(stable), 64'd1);
        check("bp in_ready low", 64'(rdy_low), 64'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("bp in_ready on release", 64'(bus.in_ready), 64'd1);
        step();
        check("bp out_valid after release", 64'(bus.out_valid), 64'd0);
        check("bp busy after release", 64'(bus.busy), 64'd0);
        step();
        check("bp stays idle", 64'(bus.busy), 64'd0);

        // Reset in round 7 aborts, then a fresh block works
        send(vecs[0].key, vecs[0].data, 1'b0, "rst");
        for (int k = 0; k < 6; k++) step();
        check("rst round_idx before abort", 64'(bus.round_idx), 64'd7);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 64'(bus.out_valid), 64'd0);
        check("abort busy",      64'(bus.busy),      64'd0);
        check("abort in_ready",  64'(bus.in_ready),  64'd1);
        check("abort round_idx", 64'(bus.round_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post-abort idle", 64'(bus.out_valid), 64'd0);
        send(vecs[1].key, vecs[1].data, 1'b0, "post-abort");
        run_to_done(cyc);
        check("post-abort latency", 64'(cyc), 64'd16);
        check("post-abort out_data", bus.out_data, vecs[1].exp_out);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
